mux_scan_ctrl: RTL and testbench

Upstream sequencer for the parameterized N:1 `mux`. It drives the mux `sel` input across a masked set of channels and holds each selection for a programmable settle time. At the end of each hold it samples the mux output `Y` back into a channel-indexed result word, and it reports completion with a one-cycle `done` pulse. The result is an N-bit snapshot of the mux inputs taken through the mux itself.

---
 rtl/mux_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Sequencer that steps an N:1 mux select across a masked channel set and samples y into a result word.
// Optional abort input enabled by defining MUX_SCAN_ABORT_EN.
module mux_scan_ctrl #(
    parameter int unsigned N     = 16,
    parameter int unsigned DWELL = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N-1:0]         en_mask,
    input  logic                 y,
`ifdef MUX_SCAN_ABORT_EN
    input  logic                 abort,
`endif
    output logic [$clog2(N)-1:0] sel,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         data
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    // S_EMPTY delays an empty-mask scan by one cycle so done lands after edge k+1
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_EMPTY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [N-1:0]  mask;
    logic [N-1:0]  shadow;
    logic [CW-1:0] cnt;

    logic [SW-1:0] first_ch_c;
    logic [SW-1:0] next_ch_c;
    logic          next_ok_c;
    logic [N-1:0]  shadow_upd_c;
    logic          abort_hit_c;

`ifdef MUX_SCAN_ABORT_EN
    assign abort_hit_c = abort;
`else
    assign abort_hit_c = 1'b0;
`endif

    // Lowest enabled channel of the incoming mask, and next higher channel of the captured mask
    always_comb begin
        first_ch_c = '0;
        next_ch_c  = '0;
        next_ok_c  = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                first_ch_c = SW'(i);
            end
            if (mask[i] && (i > int'(sel))) begin
                next_ch_c = SW'(i);
                next_ok_c = 1'b1;
            end
        end
    end

    always_comb begin
        shadow_upd_c      = shadow;
        shadow_upd_c[sel] = y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sel    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            data   <= '0;
            mask   <= '0;
            shadow <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    sel  <= '0;
                    busy <= 1'b0;
                    if (start) begin
                        mask   <= en_mask;
                        shadow <= '0;
                        if (|en_mask) begin
                            state <= S_SCAN;
                            sel   <= first_ch_c;
                            cnt   <= RELOAD;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_EMPTY;
                        end
                    end
                end
                S_SCAN: begin
                    if (abort_hit_c) begin
                        state <= S_IDLE;
                        sel   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shadow <= shadow_upd_c;
                        if (next_ok_c) begin
                            sel <= next_ch_c;
                            cnt <= RELOAD;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            data  <= shadow_upd_c;
                        end
                    end
                end
                S_EMPTY: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    data  <= shadow;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    sel   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    sel   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized self-checking bench for mux_scan_ctrl with a behavioural mux and channel-list scan model.
// Define MUX_SCAN_ABORT_EN to also exercise the abort input.
module tb_mux_scan_ctrl;

    localparam int unsigned N  = 16;
    localparam int unsigned DW = 2;
    localparam int unsigned SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  en_mask;
    logic [N-1:0]  mux_in;
    logic          y;
    logic          abort;
    logic [SW-1:0] sel;
    logic          busy;
    logic          done;
    logic [N-1:0]  data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural mux: y follows sel combinationally
    assign y = mux_in[sel];

    mux_scan_ctrl #(.N(N), .DWELL(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .en_mask (en_mask),
        .y       (y),
`ifdef MUX_SCAN_ABORT_EN
        .abort   (abort),
`endif
        .sel     (sel),
        .busy    (busy),
        .done    (done),
        .data    (data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: enabled channels in ascending order, each held DW cycles, sampled at the end of its hold
    task automatic run_scan(input logic [N-1:0] m, input logic [N-1:0] inp,
                            input logic keep_start, input logic perturb, input string name);
        int ch[$];
        logic [N-1:0] exp_data;
        mux_in   = inp;
        en_mask  = m;
        start    = 1'b1;
        exp_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (m[i]) ch.push_back(i);
        end
        step();
        if (!keep_start) start = 1'b0;
        if (ch.size() == 0) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s empty_accept done=%b busy=%b required done=0 busy=0", name, done, busy);
            end
            step();
        end else begin
            foreach (ch[idx]) begin
                for (int d = 0; d < int'(DW); d++) begin
                    checks++;
                    if (sel !== SW'(ch[idx]) || busy !== 1'b1 || done !== 1'b0) begin
                        errors++;
                        $display("FAIL %s hold ch%0d cyc%0d sel=%0d busy=%b done=%b required sel=%0d busy=1 done=0",
                                 name, idx, d, sel, busy, done, ch[idx]);
                    end
                    if (perturb && idx == 1 && d == 0) begin
                        en_mask = N'($urandom);
                        mux_in  = N'($urandom);
                    end
                    if (d == int'(DW) - 1) exp_data[ch[idx]] = mux_in[ch[idx]];
                    step();
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || data !== exp_data) begin
            errors++;
            $display("FAIL %s done_cycle done=%b busy=%b data=%h required done=1 busy=0 data=%h",
                     name, done, busy, data, exp_data);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sel !== '0 || data !== exp_data) begin
            errors++;
            $display("FAIL %s idle_after done=%b busy=%b sel=%0d data=%h required done=0 busy=0 sel=0 data=%h",
                     name, done, busy, sel, data, exp_data);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        en_mask = '0;
        mux_in  = '0;
        abort   = 1'b0;
        #12;
        checks++;
        if (sel !== '0 || busy !== 1'b0 || done !== 1'b0 || data !== '0) begin
            errors++;
            $display("FAIL reset sel=%0d busy=%b done=%b data=%h required all zero", sel, busy, done, data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_mask();
        run_scan(16'hFFFF, 16'hA5C3, 1'b0, 1'b0, "full_mask");
        checks++;
        if (data !== 16'hA5C3) begin
            errors++;
            $display("FAIL full_mask_value data=%h required a5c3", data);
        end
    endtask

    task automatic test_sparse_mask();
        run_scan(16'h8001, 16'hFFFF, 1'b0, 1'b0, "sparse_mask");
        checks++;
        if (data !== 16'h8001) begin
            errors++;
            $display("FAIL sparse_mask_value data=%h required 8001", data);
        end
    endtask

    task automatic test_empty_mask();
        run_scan(16'h0000, 16'hFFFF, 1'b0, 1'b0, "empty_mask");
    endtask

    task automatic test_start_held();
        run_scan(16'h00F0, N'($urandom), 1'b1, 1'b1, "start_held_first");
        // start is still high: the next scan is accepted in this IDLE cycle
        run_scan(16'h0300, N'($urandom), 1'b0, 1'b0, "start_held_second");
    endtask

    task automatic test_random();
        logic [N-1:0] m;
        for (int t = 0; t < 8; t++) begin
            m = N'($urandom);
            if (t % 2 == 1) m = m & N'($urandom) & N'($urandom);
            run_scan(m, N'($urandom), 1'b0, (t % 3 == 0), "random");
        end
    endtask

    task automatic test_reset_mid_scan();
        run_scan(16'hFFFF, 16'h5A3C, 1'b0, 1'b0, "pre_reset");
        en_mask = 16'hFFFF;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== '0 || busy !== 1'b0 || done !== 1'b0 || data !== '0) begin
            errors++;
            $display("FAIL reset_mid_scan sel=%0d busy=%b done=%b data=%h required all zero", sel, busy, done, data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (sel !== '0 || busy !== 1'b0 || done !== 1'b0 || data !== '0) begin
            errors++;
            $display("FAIL reset_release_idle sel=%0d busy=%b done=%b data=%h required all zero", sel, busy, done, data);
        end
    endtask

`ifdef MUX_SCAN_ABORT_EN
    task automatic test_abort();
        run_scan(16'h1234, 16'hFFFF, 1'b0, 1'b0, "abort_preload");
        en_mask = 16'hFFFF;
        mux_in  = 16'hFFFF;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (sel !== '0 || busy !== 1'b0 || done !== 1'b0 || data !== 16'h1234) begin
            errors++;
            $display("FAIL abort sel=%0d busy=%b done=%b data=%h required sel=0 busy=0 done=0 data=1234",
                     sel, busy, done, data);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || data !== 16'h1234) begin
                errors++;
                $display("FAIL abort_quiet cyc%0d done=%b busy=%b data=%h required done=0 busy=0 data=1234",
                         i, done, busy, data);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_empty_mask();
        test_start_held();
        test_random();
`ifdef MUX_SCAN_ABORT_EN
        test_abort();
`endif
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
